// File: rtl/face_point.sv
// Catmull-Clark face-point engine: reads each quad's four vertices from RAM_V and
// writes their centroid (x, y, z) to RAM_F. Block state advances on negedge clk.
module face_point #(
   parameter int ADDR_WIDTH = 9,
   parameter int FACE_BASE  = 0,
   parameter int VERT_BASE  = 256,
   parameter int OUT_BASE   = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [7:0]            face_count,
   input  logic [31:0]           RAM_V_Do,
   output logic                  RAM_V_EN,
   output logic [ADDR_WIDTH-1:0] RAM_V_A,
   output logic [3:0]            RAM_V_WE,
   output logic                  RAM_F_EN,
   output logic [ADDR_WIDTH-1:0] RAM_F_A,
   output logic [3:0]            RAM_F_WE,
   output logic [31:0]           RAM_F_Di,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [2:0] {S_IDLE, S_FACE_RD, S_VERT_RD, S_WRITE, S_FIN} state_t;

   state_t                 r_state, w_state_nxt;
   logic [4:0]             r_cyc;
   logic [7:0]             r_f, r_count;
   logic [31:0]            r_face;
   logic [1:0]             r_rd_v, r_rd_c, r_acc_sel;
   logic signed [33:0]     r_acc_x, r_acc_y, r_acc_z;
   logic signed [31:0]     r_pt_x, r_pt_y, r_pt_z;
   logic [ADDR_WIDTH-1:0]  r_wr_a, r_v_a, r_f_a;
   logic [31:0]            r_f_di;
   logic [3:0]             r_f_we;
   logic                   r_en, r_busy, r_done;

   logic                   w_en_nxt, w_busy_nxt, w_done_nxt;
   logic [3:0]             w_f_we_nxt;
   logic                   w_last_face;
   logic [31:0]            w_sel_word;
   logic [7:0]             w_vidx;
   logic [ADDR_WIDTH-1:0]  w_vaddr, w_faddr, w_oaddr;
   logic signed [33:0]     w_do_ext;

   function automatic logic signed [31:0] centroid(input logic signed [33:0] acc);
      return 32'(acc >>> 2);
   endfunction

   assign w_last_face = ({1'b0, r_f} + 9'd1) == {1'b0, r_count};
   // At c1 the face word is still on the RAM bus; later reads use the captured copy.
   assign w_sel_word  = (r_cyc == 5'd1) ? RAM_V_Do : r_face;
   assign w_do_ext    = {{2{RAM_V_Do[31]}}, RAM_V_Do};
   assign w_faddr     = ADDR_WIDTH'(FACE_BASE) + ADDR_WIDTH'(r_f);
   assign w_oaddr     = ADDR_WIDTH'(OUT_BASE) + ADDR_WIDTH'(r_f) * ADDR_WIDTH'(3);
   assign w_vaddr     = ADDR_WIDTH'(VERT_BASE) + ADDR_WIDTH'(w_vidx) * ADDR_WIDTH'(3)
                        + ADDR_WIDTH'(r_rd_c);

   always_comb begin
      case (r_rd_v)
         2'd0:    w_vidx = w_sel_word[7:0];
         2'd1:    w_vidx = w_sel_word[15:8];
         2'd2:    w_vidx = w_sel_word[23:16];
         default: w_vidx = w_sel_word[31:24];
      endcase
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (start) w_state_nxt = (face_count == 8'd0) ? S_FIN : S_FACE_RD;
         S_FACE_RD: if (r_cyc == 5'd1) w_state_nxt = S_VERT_RD;
         S_VERT_RD: if (r_cyc == 5'd14) w_state_nxt = S_WRITE;
         S_WRITE:   if (r_cyc == 5'd17) w_state_nxt = w_last_face ? S_FIN : S_FACE_RD;
         S_FIN:     w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_en_nxt   = r_en;
      w_busy_nxt = r_busy;
      w_done_nxt = 1'b0;
      w_f_we_nxt = 4'b0000;
      case (r_state)
         S_IDLE:  if (start) begin
                     w_en_nxt   = 1'b1;
                     w_busy_nxt = 1'b1;
                  end
         S_WRITE: w_f_we_nxt = 4'b1111;
         S_FIN:   begin
                     w_en_nxt   = 1'b0;
                     w_busy_nxt = 1'b0;
                     w_done_nxt = 1'b1;
                  end
         default: ;
      endcase
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en <= 1'b0;  r_busy <= 1'b0;  r_done <= 1'b0;  r_f_we <= 4'b0000;
         r_v_a <= '0;   r_f_a <= '0;     r_f_di <= '0;    r_wr_a <= '0;
         r_cyc <= '0;   r_f <= '0;       r_count <= '0;   r_face <= '0;
         r_rd_v <= '0;  r_rd_c <= '0;    r_acc_sel <= '0;
         r_acc_x <= '0; r_acc_y <= '0;   r_acc_z <= '0;
         r_pt_x <= '0;  r_pt_y <= '0;    r_pt_z <= '0;
      end else begin
         r_en   <= w_en_nxt;
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
         r_f_we <= w_f_we_nxt;
         if (r_state == S_IDLE) begin
            if (start) begin
               r_count <= face_count;
               r_f     <= '0;
               r_cyc   <= '0;
            end
         end else if (r_state != S_FIN) begin
            r_cyc <= (r_cyc == 5'd17) ? 5'd0 : r_cyc + 5'd1;
            if (r_cyc == 5'd0) begin
               r_v_a   <= w_faddr;
               r_acc_x <= '0;
               r_acc_y <= '0;
               r_acc_z <= '0;
               r_rd_v  <= '0;
               r_rd_c  <= '0;
            end
            if (r_cyc == 5'd1) r_face <= RAM_V_Do;
            if (r_cyc >= 5'd1 && r_cyc <= 5'd12) begin
               r_v_a     <= w_vaddr;
               r_acc_sel <= r_rd_c;
               if (r_rd_c == 2'd2) begin
                  r_rd_c <= 2'd0;
                  r_rd_v <= r_rd_v + 2'd1;
               end else begin
                  r_rd_c <= r_rd_c + 2'd1;
               end
            end
            // Read data lags its address by one edge, so r_acc_sel names the returning component.
            if (r_cyc >= 5'd2 && r_cyc <= 5'd13) begin
               case (r_acc_sel)
                  2'd0:    r_acc_x <= r_acc_x + w_do_ext;
                  2'd1:    r_acc_y <= r_acc_y + w_do_ext;
                  default: r_acc_z <= r_acc_z + w_do_ext;
               endcase
            end
            if (r_cyc == 5'd14) begin
               r_pt_x <= centroid(r_acc_x);
               r_pt_y <= centroid(r_acc_y);
               r_pt_z <= centroid(r_acc_z);
               r_wr_a <= w_oaddr;
            end
            if (r_cyc >= 5'd15) begin
               r_f_a  <= r_wr_a;
               r_wr_a <= r_wr_a + ADDR_WIDTH'(1);
               case (r_cyc)
                  5'd15:   r_f_di <= r_pt_x;
                  5'd16:   r_f_di <= r_pt_y;
                  default: r_f_di <= r_pt_z;
               endcase
            end
            if (r_cyc == 5'd17) r_f <= r_f + 8'd1;
         end
      end
   end

   assign RAM_V_EN = r_en;
   assign RAM_V_A  = r_v_a;
   assign RAM_V_WE = 4'b0000;
   assign RAM_F_EN = r_en;
   assign RAM_F_A  = r_f_a;
   assign RAM_F_WE = r_f_we;
   assign RAM_F_Di = r_f_di;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_face_point.sv
// Directed bench for face_point with behavioural DFFRAM models for RAM_V and RAM_F.
module tb_face_point;

   localparam int AW = 9;
   localparam logic [31:0] SENT = 32'hDEAD_BEEF;

   logic          clk, rst_n, start, clr_f;
   logic [7:0]    face_count;
   logic [31:0]   RAM_V_Do, RAM_F_Di;
   logic          RAM_V_EN, RAM_F_EN, busy, done;
   logic [AW-1:0] RAM_V_A, RAM_F_A;
   logic [3:0]    RAM_V_WE, RAM_F_WE;

   logic [31:0]   mem_v [0:511];
   logic [31:0]   mem_f [0:511];
   logic [AW-1:0] wr_log [0:255];
   int            wr_n;
   int            n_checks, n_errors;

   face_point #(.ADDR_WIDTH(AW), .FACE_BASE(0), .VERT_BASE(256), .OUT_BASE(0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .face_count(face_count),
      .RAM_V_Do(RAM_V_Do), .RAM_V_EN(RAM_V_EN), .RAM_V_A(RAM_V_A), .RAM_V_WE(RAM_V_WE),
      .RAM_F_EN(RAM_F_EN), .RAM_F_A(RAM_F_A), .RAM_F_WE(RAM_F_WE), .RAM_F_Di(RAM_F_Di),
      .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (RAM_V_EN) RAM_V_Do <= mem_v[RAM_V_A];
   end

   initial wr_n = 0;
   always @(posedge clk) begin
      if (clr_f) begin
         for (int i = 0; i < 512; i++) mem_f[i] <= SENT;
      end else if (RAM_F_EN && RAM_F_WE != 4'b0000) begin
         for (int b = 0; b < 4; b++)
            if (RAM_F_WE[b]) mem_f[RAM_F_A][8*b +: 8] <= RAM_F_Di[8*b +: 8];
         wr_log[wr_n[7:0]] <= RAM_F_A;
         wr_n <= wr_n + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_f();
      @(negedge clk); clr_f = 1'b1;
      @(negedge clk); clr_f = 1'b0;
   endtask

   task automatic run_faces(input logic [7:0] n, input int restart_at,
                            output int done_edge, output int busy_cnt, output int done_cnt,
                            output int rises, output int we_cnt, output int vwe_cnt);
      logic prev_busy;
      done_edge = 0; busy_cnt = 0; done_cnt = 0; rises = 0; we_cnt = 0; vwe_cnt = 0;
      prev_busy = 1'b0;
      @(posedge clk); start = 1'b1; face_count = n;
      for (int e = 1; e <= 18 * int'(n) + 8; e++) begin
         @(negedge clk); #1;
         if (e == 1) begin
            start = 1'b0;
            face_count = 8'd5;
         end
         if (e == restart_at) start = 1'b1;
         else if (e == restart_at + 1) start = 1'b0;
         if (busy) busy_cnt++;
         if (busy && !prev_busy) rises++;
         prev_busy = busy;
         if (done) begin
            done_cnt++;
            if (done_edge == 0) done_edge = e;
         end
         if (RAM_F_WE != 4'b0000) we_cnt++;
         if (RAM_V_WE != 4'b0000) vwe_cnt++;
      end
   endtask

   int de, bc, dc, rs, wc, vc, w0;

   initial begin
      n_checks = 0; n_errors = 0;
      rst_n = 1'b0; start = 1'b0; clr_f = 1'b0; face_count = 8'd0;
      for (int i = 0; i < 512; i++) mem_v[i] = 32'd0;
      mem_v[0] = 32'h03020100;
      mem_v[1] = 32'h07060504;
      mem_v[2] = 32'h02010101;
      for (int i = 0; i < 4; i++) begin
         mem_v[256 + 3*i]     = 32'(4 * (i + 1));
         mem_v[256 + 3*i + 1] = 32'd0;
         mem_v[256 + 3*i + 2] = 32'hFFFF_FFFC;
         mem_v[268 + 3*i]     = (i == 3) ? 32'd0 : 32'hFFFF_FFFF;
         mem_v[268 + 3*i + 1] = 32'h7FFF_FFFF;
         mem_v[268 + 3*i + 2] = 32'h8000_0000;
      end

      repeat (2) @(negedge clk); #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_en", {RAM_V_EN, RAM_F_EN}, 0);
      chk("rst_we", {RAM_V_WE, RAM_F_WE}, 0);
      chk("rst_addr", {RAM_V_A, RAM_F_A}, 0);
      chk("rst_di", RAM_F_Di, 0);
      #1 rst_n = 1'b1;
      clear_f();

      // one face, basic centroid
      run_faces(8'd1, -1, de, bc, dc, rs, wc, vc);
      chk("t1_done_edge", de, 20);
      chk("t1_busy_edges", bc, 19);
      chk("t1_done_cnt", dc, 1);
      chk("t1_we_cnt", wc, 3);
      chk("t1_vwe", vc, 0);
      chk("t1_fx", mem_f[0], 32'd10);
      chk("t1_fy", mem_f[1], 32'd0);
      chk("t1_fz", mem_f[2], 32'hFFFF_FFFC);

      // zero faces
      run_faces(8'd0, -1, de, bc, dc, rs, wc, vc);
      chk("t0_done_edge", de, 2);
      chk("t0_busy_edges", bc, 1);
      chk("t0_done_cnt", dc, 1);
      chk("t0_we_cnt", wc, 0);

      // three faces: floor rounding, full-scale sums, repeated vertices
      clear_f();
      w0 = wr_n;
      run_faces(8'd3, -1, de, bc, dc, rs, wc, vc);
      chk("t3_done_edge", de, 56);
      chk("t3_busy_edges", bc, 55);
      chk("t3_busy_rises", rs, 1);
      chk("t3_done_cnt", dc, 1);
      chk("t3_wr_n", wr_n - w0, 9);
      for (int i = 0; i < 9; i++) chk("t3_wr_order", 32'(wr_log[(w0 + i) % 256]), i);
      chk("t3_f0x", mem_f[0], 32'd10);
      chk("t3_f0z", mem_f[2], 32'hFFFF_FFFC);
      chk("t3_f1x_floor", mem_f[3], 32'hFFFF_FFFF);
      chk("t3_f1y_max", mem_f[4], 32'h7FFF_FFFF);
      chk("t3_f1z_min", mem_f[5], 32'h8000_0000);
      chk("t3_f2x_rep", mem_f[6], 32'd9);
      chk("t3_f2y", mem_f[7], 32'd0);
      chk("t3_f2z", mem_f[8], 32'hFFFF_FFFC);

      // start pulsed mid-run is ignored
      run_faces(8'd2, 10, de, bc, dc, rs, wc, vc);
      chk("tr_done_edge", de, 38);
      chk("tr_busy_edges", bc, 37);
      chk("tr_busy_rises", rs, 1);
      chk("tr_done_cnt", dc, 1);
      chk("tr_we_cnt", wc, 6);

      // reset asserted at face 1 cycle 16
      clear_f();
      @(posedge clk); start = 1'b1; face_count = 8'd2;
      @(negedge clk); #1; start = 1'b0;
      repeat (35) @(negedge clk);
      #1;
      chk("ta_pre_we", RAM_F_WE, 4'b1111);
      chk("ta_pre_addr", 32'(RAM_F_A), 4);
      #1 rst_n = 1'b0;
      #1;
      chk("ta_busy", busy, 0);
      chk("ta_en", {RAM_V_EN, RAM_F_EN}, 0);
      chk("ta_we", RAM_F_WE, 0);
      chk("ta_addr", {RAM_V_A, RAM_F_A}, 0);
      chk("ta_di", RAM_F_Di, 0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      chk("ta_idle_busy", busy, 0);
      chk("ta_idle_en", RAM_V_EN, 0);
      chk("ta_f3_done", mem_f[3], 32'hFFFF_FFFF);
      chk("ta_f4_cut", mem_f[4], SENT);
      chk("ta_f5_cut", mem_f[5], SENT);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
